// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM receiver recovering a 4-bit duty code from high time and period
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [3:0]       duty_cycle,
    output logic             valid,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    localparam int               DW      = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] period_cnt_q, high_cnt_q;
    logic [CNT_W-1:0] hi_r_q, per_r_q;
    logic [DW-1:0]    rem_q, dvs_q;
    logic [4:0]       quo_q;
    logic [2:0]       step_q;
    logic [3:0]       duty_q;
    logic             valid_q, stuck_q, overrun_q;
    logic [CNT_W-1:0] high_time_q, period_q;

    logic             rise, timeout_hit, q_bit;
    logic [CNT_W-1:0] period_cnt_d, high_cnt_d;
    logic [DW-1:0]    rem_d;
    logic [4:0]       quo_d;
    logic [3:0]       duty_d;

    always_comb begin
        rise         = s2_q & ~s3_q;
        timeout_hit  = !rise && !stuck_q && (state_q != DIVIDE) && (period_cnt_q == TO_CNT);
        period_cnt_d = rise ? CNT_ONE :
                       (period_cnt_q == CNT_MAX) ? period_cnt_q : period_cnt_q + CNT_ONE;
        high_cnt_d   = rise ? CNT_ONE :
                       (s2_q && high_cnt_q != CNT_MAX) ? high_cnt_q + CNT_ONE : high_cnt_q;
        // Divisor is pre-shifted by 4 and walks right, so each step yields one quotient bit
        q_bit        = (rem_q >= dvs_q);
        rem_d        = q_bit ? rem_q - dvs_q : rem_q;
        quo_d        = {quo_q[3:0], q_bit};
        // A zero period makes every step succeed, so it lands in the saturated branch too
        duty_d       = quo_d[4] ? 4'hF : quo_d[3:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            hi_r_q       <= '0;
            per_r_q      <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
            high_time_q  <= '0;
            period_q     <= '0;
        end else begin
            s1_q         <= pwm_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            if (rise) begin
                stuck_q <= 1'b0;
            end
            if (timeout_hit) begin
                stuck_q     <= 1'b1;
                duty_q      <= s2_q ? 4'hF : 4'h0;
                high_time_q <= '0;
                period_q    <= '0;
                valid_q     <= 1'b1;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            hi_r_q  <= high_cnt_q;
                            per_r_q <= period_cnt_q;
                            rem_q   <= {high_cnt_q, 4'b0000};
                            dvs_q   <= {period_cnt_q, 4'b0000};
                            quo_q   <= '0;
                            step_q  <= '0;
                            state_q <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        if (rise) begin
                            overrun_q <= 1'b1;
                            state_q   <= MEASURE;
                        end else begin
                            rem_q  <= rem_d;
                            dvs_q  <= dvs_q >> 1;
                            quo_q  <= quo_d;
                            step_q <= step_q + 3'd1;
                            if (step_q == 3'd4) begin
                                duty_q      <= duty_d;
                                high_time_q <= hi_r_q;
                                period_q    <= per_r_q;
                                valid_q     <= 1'b1;
                                state_q     <= MEASURE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign duty_cycle = duty_q;
    assign valid      = valid_q;
    assign high_time  = high_time_q;
    assign period     = period_q;
    assign stuck      = stuck_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized bench for pwm_capture against an edge-level reference model
module tb_pwm_capture;
    localparam int CNT_W = 16;
    localparam int TO    = 1100;
    localparam int NMAX  = 16384;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pwm_in = 1'b0;
    logic [3:0]       duty_cycle;
    logic             valid;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             stuck;
    logic             overrun;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .valid      (valid),
        .high_time  (high_time),
        .period     (period),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Expected output events, indexed by the clock edge (counted from reset release) after which they show
    bit lvl_h   [NMAX];
    bit e_valid [NMAX];
    bit e_over  [NMAX];
    bit e_sset  [NMAX];
    bit e_sclr  [NMAX];
    int e_duty  [NMAX];
    int e_hi    [NMAX];
    int e_per   [NMAX];

    int cur_duty, cur_hi, cur_per;
    bit cur_stuck;
    bit armed, stuck_m, prev_lvl;
    int last_rise, div_from, samp, kvis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NMAX; i++) begin
            lvl_h[i] = 1'b0; e_valid[i] = 1'b0; e_over[i] = 1'b0;
            e_sset[i] = 1'b0; e_sclr[i] = 1'b0;
            e_duty[i] = 0; e_hi[i] = 0; e_per[i] = 0;
        end
        cur_duty = 0; cur_hi = 0; cur_per = 0; cur_stuck = 1'b0;
        armed = 1'b0; stuck_m = 1'b0; prev_lvl = 1'b0;
        // The timeout after reset behaves as if an edge occurred two samples before release
        last_rise = -2; div_from = -100; samp = 0; kvis = 0;
    endtask

    task automatic model_sample(input bit lvl);
        int m, hi, per, d;
        m = samp;
        if (m + 8 >= NMAX) begin
            $display("FAIL model_range: got %0d, expected below %0d", m, NMAX - 8);
            $fatal(1, "model history exhausted");
        end
        lvl_h[m] = lvl;
        if (lvl && !prev_lvl) begin
            if (stuck_m) begin
                e_sclr[m+2] = 1'b1;
                stuck_m = 1'b0;
            end
            if (!armed) begin
                armed = 1'b1;
            end else if (div_from >= 0 && m - div_from <= 5) begin
                e_over[m+2] = 1'b1;
                e_valid[div_from+7] = 1'b0;
                div_from = -100;
            end else begin
                hi = 0;
                for (int i = last_rise; i < m; i++) hi += int'(lvl_h[i]);
                per = m - last_rise;
                d = (hi * 16) / per;
                if (d > 15) d = 15;
                e_valid[m+7] = 1'b1; e_duty[m+7] = d; e_hi[m+7] = hi; e_per[m+7] = per;
                div_from = m;
            end
            last_rise = m;
        end else if (!stuck_m && m == last_rise + TO) begin
            stuck_m = 1'b1;
            armed = 1'b0;
            e_sset[m+2] = 1'b1;
            e_valid[m+2] = 1'b1; e_duty[m+2] = lvl ? 15 : 0; e_hi[m+2] = 0; e_per[m+2] = 0;
        end
        prev_lvl = lvl;
        samp++;
    endtask

    task automatic check_cycle();
        int k;
        k = kvis;
        if (e_valid[k]) begin
            cur_duty = e_duty[k]; cur_hi = e_hi[k]; cur_per = e_per[k];
        end
        if (e_sset[k]) cur_stuck = 1'b1;
        if (e_sclr[k]) cur_stuck = 1'b0;
        chk("valid", valid, e_valid[k]);
        chk("overrun", overrun, e_over[k]);
        chk("stuck", stuck, cur_stuck);
        chk("duty_cycle", duty_cycle, cur_duty);
        chk("high_time", high_time, cur_hi);
        chk("period", period, cur_per);
        kvis++;
    endtask

    task automatic step(input bit lvl);
        pwm_in = lvl;
        model_sample(lvl);
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic hold(input bit lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic periods(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++) step(i < hi);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"}, duty_cycle, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_high"}, high_time, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int per, hi;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;
        model_reset();

        hold(1'b0, TO + 10);
        periods(16, 4, 6);
        for (int code = 15; code >= 0; code--) periods(16, code, 3);
        hold(1'b0, TO + 10);
        hold(1'b0, 3);
        hold(1'b1, TO + 20);
        hold(1'b0, 5);
        periods(20, 7, 3);
        periods(4, 2, 10);
        periods(1000, 333, 3);
        periods(TO, 5, 3);
        periods(TO + 1, 5, 2);
        for (int r = 0; r < 30; r++) begin
            per = $urandom_range(6, 40);
            hi  = $urandom_range(0, per);
            periods(per, hi, $urandom_range(1, 3));
        end
        for (int r = 0; r < 10; r++) begin
            per = $urandom_range(2, 8);
            periods(per, $urandom_range(1, per - 1), $urandom_range(1, 4));
        end
        for (int r = 0; r < 200; r++) step(1'($urandom_range(0, 1)));

        periods(16, 4, 3);
        hold(1'b1, 4);
        step(1'b0);
        reset = 1'b0;
        #1;
        chk_zero("mid_div_rst");
        pwm_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        periods(16, 4, 4);
        hold(1'b0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
